// File: rtl/l2_cache_sa_wb_if.sv
// l2_cache_sa_wb_if: core-bus, flush and memory-port signals
// of the shared L2 cache, grouped for a single port connection.
interface l2_cache_sa_wb_if;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [3:0]  s_be;
   logic        s_we;
   logic        s_en;
   logic [31:0] s_rdata;
   logic        s_ready;
   logic        flush_req;
   logic        flush_done;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_we;
   logic        mem_req;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  s_addr, s_wdata, s_be, s_we, s_en,
      output s_rdata, s_ready,
      input  flush_req,
      output flush_done,
      output mem_addr, mem_wdata, mem_be, mem_we, mem_req,
      input  mem_rdata, mem_ready
   );

   modport master (
      output s_addr, s_wdata, s_be, s_we, s_en,
      input  s_rdata, s_ready,
      output flush_req,
      input  flush_done,
      input  mem_addr, mem_wdata, mem_be, mem_we, mem_req,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/l2_cache_sa_wb.sv
// l2_cache_sa_wb: set-associative, write-back, write-allocate
// L2 cache between the core bus and the memory port.
module l2_cache_sa_wb #(
   parameter int NUM_WAYS       = 2,
   parameter int NUM_SETS       = 512,
   parameter int WORDS_PER_LINE = 4
) (
   input logic             clk,
   input logic             rst_n,
   l2_cache_sa_wb_if.slave bus
);

   localparam int INDEX_BITS  = $clog2(NUM_SETS);
   localparam int LINE_BITS   = $clog2(WORDS_PER_LINE);
   localparam int OFFSET_BITS = LINE_BITS + 2;
   localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
   localparam int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   localparam logic [INDEX_BITS-1:0] LAST_SET  = INDEX_BITS'(NUM_SETS - 1);
   localparam logic [WAY_BITS-1:0]   LAST_WAY  = WAY_BITS'(NUM_WAYS - 1);
   localparam logic [LINE_BITS-1:0]  LAST_BEAT = LINE_BITS'(WORDS_PER_LINE - 1);
   localparam logic [WAY_BITS-1:0]   RR_STEP   = WAY_BITS'(NUM_WAYS > 1);

   typedef enum logic [2:0] {
      IDLE, WB, FILL, UPDATE, FLUSH_SCAN, FLUSH_DONE
   } state_t;

   logic [TAG_BITS-1:0]   tag_q  [NUM_WAYS][NUM_SETS];
   logic [31:0]           data_q [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
   logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
   logic [WAY_BITS-1:0]   rr_q    [NUM_SETS];
   logic [31:0]           fill_q  [WORDS_PER_LINE];

   state_t                state_q;
   logic [LINE_BITS-1:0]  beat_q;
   logic [WAY_BITS-1:0]   vic_q;
   logic [INDEX_BITS-1:0] wb_set_q;
   logic                  flush_q;
   logic [INDEX_BITS-1:0] scan_set_q;
   logic [WAY_BITS-1:0]   scan_way_q;

   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_idx;
   logic [LINE_BITS-1:0]  req_off;
   logic                  unused_lsb;
   logic                  hit;
   logic [WAY_BITS-1:0]   hit_way;
   logic [WAY_BITS-1:0]   vic_way;
   logic                  scan_dirty;
   logic                  scan_last;

   assign req_tag    = bus.s_addr[31:32-TAG_BITS];
   assign req_idx    = bus.s_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
   assign req_off    = bus.s_addr[OFFSET_BITS-1:2];
   assign unused_lsb = ^bus.s_addr[1:0];

   assign scan_dirty = valid_q[scan_set_q][scan_way_q] &&
                       dirty_q[scan_set_q][scan_way_q];
   assign scan_last  = (scan_set_q == LAST_SET) &&
                       (scan_way_q == LAST_WAY);

   // Parallel tag compare across all ways of the addressed set.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(w);
         end
      end
   end

   // Victim: lowest invalid way, otherwise the set's round-robin way.
   always_comb begin
      vic_way = rr_q[req_idx];
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) begin
            vic_way = WAY_BITS'(w);
         end
      end
   end

   // Bus and memory outputs decoded from state and inputs.
   always_comb begin
      bus.s_ready    = 1'b0;
      bus.s_rdata    = '0;
      bus.flush_done = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_be     = '0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.s_en && hit) begin
               bus.s_ready = 1'b1;
               if (!bus.s_we) begin
                  bus.s_rdata = data_q[hit_way][req_idx][req_off];
               end
            end
         end
         WB: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_be    = 4'hF;
            bus.mem_addr  = {tag_q[vic_q][wb_set_q], wb_set_q,
                             beat_q, 2'b00};
            bus.mem_wdata = data_q[vic_q][wb_set_q][beat_q];
         end
         FILL: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {req_tag, req_idx, beat_q, 2'b00};
         end
         FLUSH_DONE: begin
            bus.flush_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Control FSM plus valid/dirty/round-robin bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         vic_q      <= '0;
         wb_set_q   <= '0;
         flush_q    <= 1'b0;
         scan_set_q <= '0;
         scan_way_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.s_en) begin
                  if (hit) begin
                     if (bus.s_we) begin
                        dirty_q[req_idx][hit_way] <= 1'b1;
                     end
                  end else begin
                     vic_q            <= vic_way;
                     wb_set_q         <= req_idx;
                     flush_q          <= 1'b0;
                     beat_q           <= '0;
                     rr_q[req_idx]    <= rr_q[req_idx] + RR_STEP;
                     if (valid_q[req_idx][vic_way] &&
                         dirty_q[req_idx][vic_way]) begin
                        state_q <= WB;
                     end else begin
                        state_q <= FILL;
                     end
                  end
               end else if (bus.flush_req) begin
                  scan_set_q <= '0;
                  scan_way_q <= '0;
                  state_q    <= FLUSH_SCAN;
               end
            end
            WB: begin
               if (bus.mem_ready) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     if (flush_q) begin
                        dirty_q[wb_set_q][vic_q] <= 1'b0;
                        state_q <= FLUSH_SCAN;
                     end else begin
                        state_q <= FILL;
                     end
                  end
               end
            end
            FILL: begin
               if (bus.mem_ready) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     state_q <= UPDATE;
                  end
               end
            end
            UPDATE: begin
               valid_q[req_idx][vic_q] <= 1'b1;
               dirty_q[req_idx][vic_q] <= 1'b0;
               state_q <= IDLE;
            end
            FLUSH_SCAN: begin
               if (scan_dirty) begin
                  vic_q    <= scan_way_q;
                  wb_set_q <= scan_set_q;
                  flush_q  <= 1'b1;
                  beat_q   <= '0;
                  state_q  <= WB;
               end else if (scan_last) begin
                  state_q <= FLUSH_DONE;
               end else if (scan_way_q == LAST_WAY) begin
                  scan_way_q <= '0;
                  scan_set_q <= scan_set_q + 1'b1;
               end else begin
                  scan_way_q <= scan_way_q + 1'b1;
               end
            end
            FLUSH_DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag/data arrays and refill buffer; contents survive reset.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && bus.s_en && hit && bus.s_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.s_be[b]) begin
               data_q[hit_way][req_idx][req_off][8*b +: 8] <=
                  bus.s_wdata[8*b +: 8];
            end
         end
      end
      if (state_q == FILL && bus.mem_ready) begin
         fill_q[beat_q] <= bus.mem_rdata;
      end
      if (state_q == UPDATE) begin
         tag_q[vic_q][req_idx] <= req_tag;
         for (int i = 0; i < WORDS_PER_LINE; i++) begin
            data_q[vic_q][req_idx][i] <= fill_q[i];
         end
      end
   end

endmodule

// File: tb/tb_l2_cache_sa_wb.sv
// tb_l2_cache_sa_wb: scoreboard bench for the L2 cache with a
// behavioural memory that returns data = address until written.
module tb_l2_cache_sa_wb;

   localparam int NW  = 2;
   localparam int NS  = 512;
   localparam int WPL = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
      logic [3:0]  be;
   } beat_t;

   logic clk;
   logic rst_n;
   l2_cache_sa_wb_if bus_if ();

   l2_cache_sa_wb #(
      .NUM_WAYS       (NW),
      .NUM_SETS       (NS),
      .WORDS_PER_LINE (WPL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int errors = 0;
   int checks = 0;
   int delay = 0;
   int wcnt = 0;
   int req_cycles = 0;
   int stab_err = 0;
   bit holding = 0;
   beat_t cur, held;
   logic [31:0] old;
   logic [31:0] model [logic [31:0]];
   beat_t act_q [$];
   beat_t exp_q [$];
   logic [31:0] exp_rd_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: waits delay cycles per beat, logs each beat.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus_if.mem_ready = 1'b0;
         wcnt = 0;
         holding = 0;
      end else if (bus_if.mem_req) begin
         req_cycles++;
         cur = '{bus_if.mem_addr, bus_if.mem_we,
                 bus_if.mem_wdata, bus_if.mem_be};
         if (holding && cur !== held) stab_err++;
         held = cur;
         holding = 1;
         if (wcnt >= delay) begin
            old = model.exists(cur.addr) ? model[cur.addr] : cur.addr;
            if (cur.we) begin
               for (int b = 0; b < 4; b++)
                  if (cur.be[b]) old[8*b +: 8] = cur.data[8*b +: 8];
               model[cur.addr] = old;
               bus_if.mem_rdata = '0;
            end else begin
               bus_if.mem_rdata = old;
            end
            bus_if.mem_ready = 1'b1;
            act_q.push_back(cur);
            wcnt = 0;
            holding = 0;
         end else begin
            bus_if.mem_ready = 1'b0;
            wcnt++;
         end
      end else begin
         bus_if.mem_ready = 1'b0;
         wcnt = 0;
         holding = 0;
      end
   end

   task automatic push_fill(input logic [31:0] base);
      for (int i = 0; i < WPL; i++)
         exp_q.push_back('{base + 32'(4 * i), 1'b0, 32'h0, 4'h0});
   endtask

   task automatic push_wb(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back('{a, 1'b1, d, 4'hF});
   endtask

   task automatic access(input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] be,
                         output int lat, output logic [31:0] rd);
      lat = -1;
      rd = '0;
      @(negedge clk);
      bus_if.s_addr = a;
      bus_if.s_we = we;
      bus_if.s_wdata = wd;
      bus_if.s_be = be;
      bus_if.s_en = 1'b1;
      for (int n = 0; n < 400; n++) begin
         #1;
         if (bus_if.s_ready) begin
            lat = n;
            rd = bus_if.s_rdata;
            break;
         end
         @(negedge clk);
      end
      if (lat >= 0) begin
         @(posedge clk);
         #1;
      end
      bus_if.s_en = 1'b0;
   endtask

   task automatic run_flush(output int n);
      n = -1;
      @(negedge clk);
      bus_if.flush_req = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         #1;
         if (bus_if.flush_done) begin
            n = i;
            break;
         end
         @(negedge clk);
      end
      bus_if.flush_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus_if.s_ready, bus_if.s_rdata, bus_if.flush_done} !== '0) begin
         errors++;
         $display("FAIL reset_bus: got %b/%h/%b required 0/0/0",
                  bus_if.s_ready, bus_if.s_rdata, bus_if.flush_done);
      end
      checks++;
      if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_be} !== '0) begin
         errors++;
         $display("FAIL reset_memctl: got %b/%b/%h required 0/0/0",
                  bus_if.mem_req, bus_if.mem_we, bus_if.mem_be);
      end
      checks++;
      if ({bus_if.mem_addr, bus_if.mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_memdata: got %h/%h required 0/0",
                  bus_if.mem_addr, bus_if.mem_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_cold_read();
      int lat, r0;
      logic [31:0] rd, er;
      beat_t e, a;
      push_fill(32'h1000);
      exp_rd_q.push_back(32'h0000_1004);
      access(32'h1004, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 6) begin
         errors++;
         $display("FAIL cold_lat: got %0d required 6", lat);
      end
      checks++;
      if (rd !== er) begin
         errors++;
         $display("FAIL cold_rdata: got %h required %h", rd, er);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cold_beat: got %h required %h", a, e);
         end
      end
      checks++;
      if (act_q.size() != 0) begin
         errors++;
         $display("FAIL cold_extra: got %0d beats required 0", act_q.size());
         act_q.delete();
      end
      r0 = req_cycles;
      exp_rd_q.push_back(32'h0000_1008);
      access(32'h1008, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 0 || rd !== er) begin
         errors++;
         $display("FAIL reread_hit: got lat %0d data %h required 0 %h",
                  lat, rd, er);
      end
      checks++;
      if (req_cycles != r0) begin
         errors++;
         $display("FAIL reread_mem: got %0d req cycles required 0",
                  req_cycles - r0);
      end
   endtask

   task automatic test_write_hit();
      int lat, r0;
      logic [31:0] rd, er;
      r0 = req_cycles;
      access(32'h1004, 1'b1, 32'hAAAA_BBBB, 4'b0011, lat, rd);
      checks++;
      if (lat !== 0 || rd !== 32'h0) begin
         errors++;
         $display("FAIL whit_ready: got lat %0d rdata %h required 0 0",
                  lat, rd);
      end
      exp_rd_q.push_back(32'h0000_BBBB);
      access(32'h1004, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 0 || rd !== er) begin
         errors++;
         $display("FAIL whit_read: got lat %0d data %h required 0 %h",
                  lat, rd, er);
      end
      checks++;
      if (req_cycles != r0) begin
         errors++;
         $display("FAIL whit_mem: got %0d req cycles required 0",
                  req_cycles - r0);
      end
   endtask

   task automatic test_evict();
      int lat;
      logic [31:0] rd, er;
      beat_t e, a;
      push_fill(32'h3000);
      exp_rd_q.push_back(32'h0000_3000);
      access(32'h3000, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 6 || rd !== er) begin
         errors++;
         $display("FAIL evict_first: got lat %0d data %h required 6 %h",
                  lat, rd, er);
      end
      push_wb(32'h1000, 32'h0000_1000);
      push_wb(32'h1004, 32'h0000_BBBB);
      push_wb(32'h1008, 32'h0000_1008);
      push_wb(32'h100C, 32'h0000_100C);
      push_fill(32'h5000);
      exp_rd_q.push_back(32'h0000_5000);
      access(32'h5000, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 10) begin
         errors++;
         $display("FAIL evict_lat: got %0d required 10", lat);
      end
      checks++;
      if (rd !== er) begin
         errors++;
         $display("FAIL evict_rdata: got %h required %h", rd, er);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL evict_beat: got %h required %h", a, e);
         end
      end
      checks++;
      if (act_q.size() != 0) begin
         errors++;
         $display("FAIL evict_extra: got %0d beats required 0", act_q.size());
         act_q.delete();
      end
   endtask

   task automatic test_flush();
      int lat, n, r0;
      logic [31:0] rd, er;
      beat_t a;
      logic [31:0] exp_fl [logic [31:0]];
      access(32'h5004, 1'b1, 32'h1234_5678, 4'hF, lat, rd);
      access(32'h3008, 1'b1, 32'hCAFE_F00D, 4'b1100, lat, rd);
      exp_fl[32'h5000] = 32'h0000_5000;
      exp_fl[32'h5004] = 32'h1234_5678;
      exp_fl[32'h5008] = 32'h0000_5008;
      exp_fl[32'h500C] = 32'h0000_500C;
      exp_fl[32'h3000] = 32'h0000_3000;
      exp_fl[32'h3004] = 32'h0000_3004;
      exp_fl[32'h3008] = 32'hCAFE_3008;
      exp_fl[32'h300C] = 32'h0000_300C;
      run_flush(n);
      checks++;
      if (n < 0) begin
         errors++;
         $display("FAIL flush_timeout: got no flush_done required pulse");
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus_if.flush_done !== 1'b0) begin
         errors++;
         $display("FAIL flush_pulse: got %b one cycle later required 0",
                  bus_if.flush_done);
      end
      checks++;
      if (act_q.size() != 8) begin
         errors++;
         $display("FAIL flush_count: got %0d beats required 8", act_q.size());
      end
      while (act_q.size() > 0) begin
         a = act_q.pop_front();
         checks++;
         if (!a.we || a.be !== 4'hF || !exp_fl.exists(a.addr) ||
             exp_fl[a.addr] !== a.data) begin
            errors++;
            $display("FAIL flush_beat: got %h required a dirty-line write",
                     a);
         end else begin
            exp_fl.delete(a.addr);
         end
      end
      checks++;
      if (exp_fl.size() != 0) begin
         errors++;
         $display("FAIL flush_missing: got %0d unwritten words required 0",
                  exp_fl.size());
      end
      r0 = req_cycles;
      exp_rd_q.push_back(32'h1234_5678);
      access(32'h5004, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 0 || rd !== er) begin
         errors++;
         $display("FAIL flush_hit0: got lat %0d data %h required 0 %h",
                  lat, rd, er);
      end
      exp_rd_q.push_back(32'hCAFE_3008);
      access(32'h3008, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 0 || rd !== er) begin
         errors++;
         $display("FAIL flush_hit1: got lat %0d data %h required 0 %h",
                  lat, rd, er);
      end
      checks++;
      if (req_cycles != r0) begin
         errors++;
         $display("FAIL flush_hitmem: got %0d req cycles required 0",
                  req_cycles - r0);
      end
   endtask

   task automatic test_flush_clean();
      int n;
      // request cycle, one scan cycle per (set, way), then done
      run_flush(n);
      checks++;
      if (n != NS * NW + 1) begin
         errors++;
         $display("FAIL flush2_cycles: got %0d required %0d",
                  n, NS * NW + 1);
      end
      checks++;
      if (act_q.size() != 0) begin
         errors++;
         $display("FAIL flush2_writes: got %0d beats required 0",
                  act_q.size());
         act_q.delete();
      end
   endtask

   task automatic test_write_miss();
      int lat;
      logic [31:0] rd, er;
      beat_t e, a;
      push_fill(32'h4100);
      access(32'h4100, 1'b1, 32'h7766_5544, 4'b1000, lat, rd);
      checks++;
      if (lat !== 6) begin
         errors++;
         $display("FAIL wmiss_lat: got %0d required 6", lat);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL wmiss_beat: got %h required %h", a, e);
         end
      end
      exp_rd_q.push_back(32'h7700_4100);
      access(32'h4100, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 0 || rd !== er) begin
         errors++;
         $display("FAIL wmiss_read: got lat %0d data %h required 0 %h",
                  lat, rd, er);
      end
   endtask

   task automatic test_slow_fill();
      int lat, r0, s0;
      logic [31:0] rd, er;
      beat_t e, a;
      delay = 5;
      r0 = req_cycles;
      s0 = stab_err;
      push_fill(32'h2040);
      exp_rd_q.push_back(32'h0000_2048);
      access(32'h2048, 1'b0, '0, 4'hF, lat, rd);
      delay = 0;
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 4 * 6 + 2 || rd !== er) begin
         errors++;
         $display("FAIL slow_read: got lat %0d data %h required 26 %h",
                  lat, rd, er);
      end
      checks++;
      if (stab_err != s0) begin
         errors++;
         $display("FAIL slow_stable: got %0d changes required 0",
                  stab_err - s0);
      end
      checks++;
      if (req_cycles - r0 != 24) begin
         errors++;
         $display("FAIL slow_reqcyc: got %0d required 24", req_cycles - r0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL slow_beat: got %h required %h", a, e);
         end
      end
      checks++;
      if (act_q.size() != 0) begin
         errors++;
         $display("FAIL slow_extra: got %0d beats required 0", act_q.size());
         act_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [31:0] rd, er;
      beat_t e, a;
      exp_q.push_back('{32'h6080, 1'b0, 32'h0, 4'h0});
      exp_q.push_back('{32'h6084, 1'b0, 32'h0, 4'h0});
      @(negedge clk);
      bus_if.s_addr = 32'h6084;
      bus_if.s_we = 1'b0;
      bus_if.s_be = 4'hF;
      bus_if.s_en = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (act_q.size() >= 2) break;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_if.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_req: got %b required 0", bus_if.mem_req);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL rstmid_beat: got %h required %h", a, e);
         end
      end
      checks++;
      if (act_q.size() != 0) begin
         errors++;
         $display("FAIL rstmid_extra: got %0d beats required 0",
                  act_q.size());
         act_q.delete();
      end
      bus_if.s_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_fill(32'h6080);
      exp_rd_q.push_back(32'h0000_6084);
      access(32'h6084, 1'b0, '0, 4'hF, lat, rd);
      er = exp_rd_q.pop_front();
      checks++;
      if (lat !== 6 || rd !== er) begin
         errors++;
         $display("FAIL rstmid_refetch: got lat %0d data %h required 6 %h",
                  lat, rd, er);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL refetch_beat: got %h required %h", a, e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus_if.s_addr = '0;
      bus_if.s_wdata = '0;
      bus_if.s_be = '0;
      bus_if.s_we = 1'b0;
      bus_if.s_en = 1'b0;
      bus_if.flush_req = 1'b0;
      bus_if.mem_rdata = '0;
      bus_if.mem_ready = 1'b0;
      test_reset();
      test_cold_read();
      test_write_hit();
      test_evict();
      test_flush();
      test_flush_clean();
      test_write_miss();
      test_slow_fill();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l2_cache_sa_wb.md
Name: l2_cache_sa_wb

Overview:
- Parametrised set-associative, write-back, write-allocate shared L2 cache between the core bus and the memory port.
- Next generation of the direct-mapped write-through L2: configurable ways, sets and line length, dirty-line eviction, and a software/coherence-driven flush.
- Bus-side and memory-side handshakes are unchanged, so it is a drop-in replacement.

Parameters:
- NUM_WAYS, 2, associativity; power of two, 1..8.
- NUM_SETS, 512, sets per way; power of two; INDEX_BITS = log2(NUM_SETS).
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, 2..16.
- Derived: OFFSET_BITS = log2(WORDS_PER_LINE) + 2; TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_addr  in  32  bus byte address.
- s_wdata  in  32  bus write data.
- s_be  in  4  bus byte enables.
- s_we  in  1  1 = write, 0 = read.
- s_en  in  1  request valid; held with addr/wdata/be/we until s_ready.
- s_rdata  out  32  read data; valid when s_ready=1 and s_we=0; otherwise 0.
- s_ready  out  1  request complete this cycle.
- flush_req  in  1  level request to write back all dirty lines; held until flush_done.
- flush_done  out  1  one-cycle pulse when flush completes.
- mem_addr  out  32  memory word address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_we  out  1  memory write.
- mem_req  out  1  memory request.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory beat complete.

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset: state=IDLE; valid, dirty and per-set victim pointers cleared; beat counter cleared.
- Reset outputs: s_ready=0, s_rdata=0, flush_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. Tag and data arrays are not reset.
- Output logic: all outputs combinational from state and inputs. Any output not driven in a state is 0.
- Lookup: all ways are compared in parallel. Hit = valid && tag match. Multiple simultaneous matches are illegal and cannot occur by construction.
- IDLE, read hit: s_ready=1 the same cycle, s_rdata = selected word. Zero wait states, no mem traffic.
- IDLE, write hit: s_ready=1 the same cycle. Byte lanes per s_be are written at the clock edge and dirty is set. No mem traffic.
- IDLE, miss (read or write):
  - Latch the victim way: lowest-numbered invalid way; else the set's round-robin pointer. Then advance the pointer.
  - Go to WB if the victim is valid and dirty; else go to FILL.
- WB: WORDS_PER_LINE write beats of the victim line, offset 0 upward.
  - mem_req=1, mem_we=1, mem_be=4'hF.
  - mem_addr = {victim tag, index, beat*4}.
  - Beat advances only on mem_ready. After the last beat, go to FILL.
- FILL: WORDS_PER_LINE read beats at {s_addr tag, index, beat*4}, mem_we=0, mem_be=0. Each beat is captured into the refill buffer on mem_ready. After the last beat, go to UPDATE.
- UPDATE (1 cycle): write the refill buffer, tag, valid=1 and dirty=0 into the victim way. Return to IDLE, where the request now hits.
- Miss latency (mem_ready always 1):
  - Clean miss: WORDS_PER_LINE + 2 cycles to s_ready.
  - Dirty miss: 2*WORDS_PER_LINE + 2 cycles to s_ready.
- s_ready: never asserted outside IDLE.
- Flush: accepted only in IDLE with s_en=0; s_en has priority when both are high.
  - FLUSH_SCAN visits every (set, way), one per cycle.
  - On a valid dirty line it performs a WB sequence, clears dirty and keeps valid, then resumes scanning.
  - After the last entry: flush_done=1 for one cycle, return to IDLE.
  - s_en requests arriving during a flush stall until it ends.
- mem_ready low: the current beat holds. mem_addr, mem_wdata and mem_be stay stable while mem_req=1.
- Reset mid-operation: immediate abort, mem_req drops asynchronously, all lines invalid. Dirty data is lost by design; software flushes before reset.
- NUM_WAYS=1: degenerates to direct-mapped write-back; the victim pointer is unused.

Test Plan:
- Cold read of 0x0000_1004; memory returns data = address:
  - Expect reads at 0x1000, 0x1004, 0x1008, 0x100C, then s_ready with s_rdata=0x0000_1004.
  - Re-read 0x1008: s_ready the same cycle, rdata 0x0000_1008, mem_req never high.
- Write hit 0x1004, s_be=4'b0011, wdata=0xAAAA_BBBB:
  - Expect s_ready the same cycle and no mem_req.
  - Read 0x1004 then returns 0x0000_BBBB.
- Dirty eviction:
  - After the above, read 0x3000 then 0x5000 (same index 0x100, 2 ways).
  - The 0x5000 miss writes 0x1000..0x100C with be=F; the beat-1 data is 0x0000_BBBB.
  - Then 4 reads from 0x5000..0x500C follow, and s_ready comes 10 cycles after the request.
- Flush with two dirty lines:
  - Expect exactly 8 write beats, a flush_done pulse, and later hits on both lines with no mem traffic.
  - A second flush produces zero writes and flush_done after NUM_SETS*NUM_WAYS scan cycles.
- mem_ready held low 5 cycles per beat during a fill:
  - mem_addr stays stable per beat, with no skipped or duplicated beats.
  - Final rdata is correct.
- rst_n low during fill beat 2:
  - mem_req goes 0 immediately.
  - After release, a read of the same address misses and refetches the full line.
